// File: rtl/instr_pkg.sv
// Shared header layout and loader state encoding for the instruction loader.
package instr_pkg;

    localparam int HDR_BANK_LSB = 0;
    localparam int HDR_BANK_W   = 8;
    localparam int HDR_CNT_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STREAM = 2'd2,
        DROP   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Stream-in and buffer-write signals of the instruction loader.
// The slave modport is the loader's view; master is the environment driving it.
interface instr_loader_if #(
    parameter int STREAM_WIDTH = 128,
    parameter int BANK_W       = 2
);
    logic [STREAM_WIDTH-1:0] s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tlast;
    logic                    s_axis_tready;
    logic [STREAM_WIDTH-1:0] idata_instr;
    logic                    idata_instr_valid;
    logic [BANK_W-1:0]       instr_bank_counter;
    logic                    idata_instr_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, idata_instr_ready,
        output s_axis_tready, idata_instr, idata_instr_valid, instr_bank_counter
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, idata_instr_ready,
        input  s_axis_tready, idata_instr, idata_instr_valid, instr_bank_counter
    );
endinterface

// File: rtl/instr_out_stage.sv
// Single-entry valid/ready output register; a load wins over a drain in the same cycle.
module instr_out_stage #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Parses header + instruction-beat packets from the host stream and steers the
// instruction beats into one bank of the instruction buffer.
//
// state  | meaning
// IDLE   | waiting for a header; output register must drain first
// SETTLE | one dead cycle so the buffer's ready reflects the new bank
// STREAM | forwarding counted instruction beats to the output register
// DROP   | discarding beats until tlast
module instr_loader
    import instr_pkg::*;
#(
    parameter int STREAM_WIDTH = 128,
    parameter int NUM_BANKS    = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_loader_if.slave bus,
    output logic          busy,
    output logic          pkt_done,
    output logic          err_bad_bank,
    output logic          err_len
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    loader_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic                  pkt_done_d, err_bad_d, err_len_d;
    logic                  load;
    logic                  tready;
    logic                  accept;
    logic                  out_valid;
    logic [HDR_BANK_W-1:0] hdr_bank;
    logic [CNT_WIDTH-1:0]  hdr_cnt;

    assign hdr_bank = bus.s_axis_tdata[HDR_BANK_LSB +: HDR_BANK_W];
    assign hdr_cnt  = bus.s_axis_tdata[HDR_CNT_LSB +: CNT_WIDTH];
    assign accept   = bus.s_axis_tvalid & tready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_d     = bank_q;
        pkt_done_d = 1'b0;
        err_bad_d  = 1'b0;
        err_len_d  = 1'b0;
        load       = 1'b0;
        tready     = 1'b0;
        case (state_q)
            IDLE: begin
                tready = !out_valid;
                if (accept) begin
                    if (hdr_bank >= HDR_BANK_W'(NUM_BANKS)) begin
                        err_bad_d = 1'b1;
                        if (!bus.s_axis_tlast) state_d = DROP;
                    end else if (hdr_cnt == '0) begin
                        if (bus.s_axis_tlast) begin
                            pkt_done_d = 1'b1;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = DROP;
                        end
                    end else if (bus.s_axis_tlast) begin
                        err_len_d = 1'b1;
                    end else begin
                        bank_d  = hdr_bank[BANK_W-1:0];
                        cnt_d   = hdr_cnt;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: state_d = STREAM;
            STREAM: begin
                tready = !out_valid || bus.idata_instr_ready;
                if (accept) begin
                    load  = 1'b1;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        if (bus.s_axis_tlast) begin
                            pkt_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = DROP;
                        end
                    end else if (bus.s_axis_tlast) begin
                        // short packet: deliver this beat, forget the rest of the count
                        err_len_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end
            DROP: begin
                tready = 1'b1;
                if (accept && bus.s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bank_q       <= '0;
            pkt_done     <= 1'b0;
            err_bad_bank <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bank_q       <= bank_d;
            pkt_done     <= pkt_done_d;
            err_bad_bank <= err_bad_d;
            err_len      <= err_len_d;
        end
    end

    instr_out_stage #(
        .WIDTH(STREAM_WIDTH)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(bus.s_axis_tdata),
        .ready    (bus.idata_instr_ready),
        .valid    (out_valid),
        .data     (bus.idata_instr)
    );

    assign bus.s_axis_tready      = tready;
    assign bus.idata_instr_valid  = out_valid;
    assign bus.instr_bank_counter = bank_q;
    assign busy                   = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed packets queue expected words,
// a negedge monitor pops and compares every word the buffer accepts.
module tb_instr_loader;

    localparam int SW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, pkt_done, err_bad_bank, err_len;

    instr_loader_if #(.STREAM_WIDTH(SW), .BANK_W(2)) bus ();

    instr_loader #(
        .STREAM_WIDTH(SW),
        .NUM_BANKS   (4),
        .CNT_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .err_bad_bank(err_bad_bank),
        .err_len     (err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] data;
        logic [1:0]    bank;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0, n_bbank = 0, n_len = 0;
    logic stall_arm = 1'b0;
    logic chk_stall = 1'b0;
    logic held = 1'b0;
    logic [SW-1:0] held_data;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] hdr(input int bank, input int cnt);
        logic [SW-1:0] h;
        h = '0;
        h[7:0]    = 8'(bank);
        h[23:8]   = 16'(cnt);
        h[127:96] = 32'hDEAD_0000; // junk outside the header fields
        return h;
    endfunction

    function automatic logic [SW-1:0] word(input int p, input int i);
        return {32'(p), 32'(i), 64'hA5A5_5A5A_F00D_BEEF};
    endfunction

    // Monitor: pops on every word handed to the buffer, checks stalls and counts pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (pkt_done)     n_done++;
                if (err_bad_bank) n_bbank++;
                if (err_len)      n_len++;
                if (bus.idata_instr_valid) begin
                    if (held) check("held_data", bus.idata_instr, held_data);
                    if (bus.idata_instr_ready) begin
                        held = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL spurious_word: got %0h expected none", bus.idata_instr);
                        end else begin
                            e = exp_q.pop_front();
                            check("word_data", bus.idata_instr, e.data);
                            check("word_bank", SW'(bus.instr_bank_counter), SW'(e.bank));
                        end
                    end else begin
                        held      = 1'b1;
                        held_data = bus.idata_instr;
                        if (chk_stall) check("tready_stalled", SW'(bus.s_axis_tready), '0);
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // Buffer back-pressure: once armed, drop ready for 3 cycles after the first word shows.
    initial begin
        bus.idata_instr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_arm && bus.idata_instr_valid) begin
                stall_arm = 1'b0;
                @(posedge clk);
                #1 bus.idata_instr_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.idata_instr_ready = 1'b1;
            end
        end
    end

    task automatic send_beat(input logic [SW-1:0] d, input logic last, output int waits);
        logic acc;
        waits = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_timeout: got no tready expected accept within 200 cycles");
                break;
            end
        end
    endtask

    task automatic idle_bus();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Header + nbeats (tlast on the final one); the first n_exp beats are expected at the buffer.
    task automatic send_pkt(input int p, input int bank, input int cnt, input int nbeats,
                            input int n_exp, output int first_waits);
        int w;
        send_beat(hdr(bank, cnt), nbeats == 0, w);
        first_waits = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (i < n_exp) exp_q.push_back({word(p, i), 2'(bank)});
            send_beat(word(p, i), i == nbeats - 1, w);
            if (i == 0) first_waits = w;
        end
        idle_bus();
    endtask

    task automatic check_pulses(input string tag, input int e_done, input int e_bb, input int e_len);
        int i;
        for (i = 0; i < 200; i++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_drained"}, SW'(busy || exp_q.size() != 0), '0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_pkt_done"}, SW'(n_done), SW'(e_done));
        check({tag, "_err_bad_bank"}, SW'(n_bbank), SW'(e_bb));
        check({tag, "_err_len"}, SW'(n_len), SW'(e_len));
        n_done  = 0;
        n_bbank = 0;
        n_len   = 0;
    endtask

    initial begin
        int w, w2;
        idle_bus();
        bus.s_axis_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", SW'(bus.idata_instr_valid), '0);
        check("rst_bank", SW'(bus.instr_bank_counter), '0);
        check("rst_busy", SW'(busy), '0);
        check("rst_pulses", SW'({pkt_done, err_bad_bank, err_len}), '0);
        check("rst_tready", SW'(bus.s_axis_tready), SW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: bank 2, three beats, one SETTLE gap
        send_pkt(1, 2, 3, 3, 3, w);
        check("t1_settle_gap", SW'(w), SW'(1));
        check_pulses("t1", 1, 0, 0);

        // 2: same packet with buffer back-pressure
        chk_stall = 1'b1;
        stall_arm = 1'b1;
        send_pkt(2, 2, 3, 3, 3, w);
        check_pulses("t2", 1, 0, 0);
        chk_stall = 1'b0;

        // 3: bank 7 is out of range; beats dropped
        send_pkt(3, 7, 2, 2, 0, w);
        check_pulses("t3", 0, 1, 0);

        // 4: count 4 but tlast on beat 2, then a normal 1-beat packet on bank 1
        send_pkt(4, 3, 4, 2, 2, w);
        send_pkt(5, 1, 1, 1, 1, w);
        check_pulses("t4", 1, 0, 1);

        // 5: count 2 but 4 beats; beats 3-4 dropped
        send_pkt(6, 0, 2, 4, 2, w);
        check_pulses("t5", 0, 0, 1);

        // 6: bank 0 then bank 1 back-to-back; reset during bank 1
        send_pkt(7, 0, 2, 2, 2, w);
        send_beat(hdr(1, 4), 1'b0, w);
        exp_q.push_back({word(8, 0), 2'd1});
        send_beat(word(8, 0), 1'b0, w);
        send_beat(word(8, 1), 1'b0, w2);
        idle_bus();
        check("t6_bank_mid", SW'(bus.instr_bank_counter), SW'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", SW'(bus.idata_instr_valid), '0);
        check("t6_rst_data", bus.idata_instr, '0);
        check("t6_rst_bank", SW'(bus.instr_bank_counter), '0);
        check("t6_rst_busy", SW'(busy), '0);
        check("t6_rst_tready", SW'(bus.s_axis_tready), SW'(1));
        check("t6_words_left", SW'(exp_q.size()), SW'(0));
        exp_q.delete();
        check("t6_pre_done", SW'(n_done), SW'(1));
        n_done = 0;
        @(negedge clk);
        check("t6_rst_pulses", SW'({pkt_done, err_bad_bank, err_len}), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(9, 1, 2, 2, 2, w);
        check("t6_restart_gap", SW'(w), SW'(1));
        check_pulses("t6", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
